// File: rtl/ps2_rx_frame_pkg.sv
// ============================================================================
//  Module   : ps2_rx_frame_pkg
//  Purpose  : Shared types and helpers for the PS/2 frame receiver.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ps2_rx_frame_pkg;

    localparam int unsigned C_DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_rx_state_t;

    // High when data plus parity bit holds an odd number of ones.
    function automatic logic odd_parity_ok(input logic [C_DATA_BITS-1:0] data,
                                           input logic par);
        return ^{data, par};
    endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ============================================================================
//  Module   : ps2_rx_fifo
//  Purpose  : First-word-fall-through byte FIFO with overflow strobe.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_fifo
    import ps2_rx_frame_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk28,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [C_DATA_BITS-1:0] push_data_i,
    input  logic                   ready_i,
    output logic [C_DATA_BITS-1:0] dout_o,
    output logic                   valid_o,
    output logic                   overflow_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [C_DATA_BITS-1:0] mem_q [DEPTH];
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          count_q,  count_d;
    logic                   w_pop;
    logic                   w_full;
    logic                   w_wr;

    assign valid_o    = (count_q != '0);
    assign dout_o     = mem_q[rd_ptr_q];
    assign w_pop      = valid_o & ready_i;
    assign w_full     = (count_q == CW'(DEPTH));
    // A pop in the same cycle frees the slot a full FIFO needs for the push.
    assign w_wr       = push_i & (~w_full | w_pop);
    assign overflow_o = push_i & w_full & ~w_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({w_wr, w_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (w_wr) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/ps2_rx_frame.sv
// ============================================================================
//  Module   : ps2_rx_frame
//  Purpose  : PS/2 frame receiver: sync, glitch filter, frame FSM, byte FIFO.
//             Optional partial-frame watchdog enabled by PS2_RX_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_rx_frame
    import ps2_rx_frame_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 28_000_000,
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT_US = 1000
) (
    input  logic       clk28,
    input  logic       rst_n,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic [7:0] dout,
    output logic       dout_valid,
    input  logic       dout_ready,
    output logic       err_parity,
    output logic       err_frame,
    output logic       err_overflow,
    output logic       err_timeout
);

    localparam int unsigned FCW      = $clog2(FILTER_LEN);
    localparam int unsigned WD_LIMIT = CLK_FREQ / 1_000_000 * TIMEOUT_US;

    logic [1:0] w_pin;
    logic [1:0] w_filt;
    logic [1:0] w_flip;

    assign w_pin = {ps2_dat_in, ps2_clk_in};

    for (genvar gi = 0; gi < 2; gi++) begin : g_filt
        logic           s1_q, s2_q, f_q;
        logic [FCW-1:0] cnt_q;

        assign w_filt[gi] = f_q;
        // Flip cycle: the filtered level changes at the end of this cycle.
        assign w_flip[gi] = (s2_q != f_q) && (cnt_q == FCW'(FILTER_LEN - 1));

        always_ff @(posedge clk28 or negedge rst_n) begin
            if (!rst_n) begin
                s1_q  <= 1'b1;
                s2_q  <= 1'b1;
                f_q   <= 1'b1;
                cnt_q <= '0;
            end else begin
                s1_q <= w_pin[gi];
                s2_q <= s1_q;
                if (s2_q == f_q) begin
                    cnt_q <= '0;
                end else if (w_flip[gi]) begin
                    f_q   <= s2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + FCW'(1);
                end
            end
        end
    end

    logic w_fall;
    logic w_bit;
    logic w_timeout;
    logic w_push;

    assign w_fall = w_filt[0] & w_flip[0];
    assign w_bit  = w_filt[1];

    ps2_rx_state_t          state_q,  state_d;
    logic [C_DATA_BITS-1:0] shreg_q,  shreg_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic                   par_q,    par_d;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            par_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            par_q    <= par_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bitcnt_d   = bitcnt_q;
        par_d      = par_q;
        w_push     = 1'b0;
        err_parity = 1'b0;
        err_frame  = 1'b0;
        if (w_timeout) begin
            state_d = ST_IDLE;
        end else if (w_fall) begin
            case (state_q)
                ST_IDLE: begin
                    if (!w_bit) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    shreg_d  = {w_bit, shreg_q[C_DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = w_bit;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    if (!w_bit) begin
                        err_frame = 1'b1;
                    end else if (!odd_parity_ok(shreg_q, par_q)) begin
                        err_parity = 1'b1;
                    end else begin
                        w_push = 1'b1;
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

`ifdef PS2_RX_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(WD_LIMIT + 1);

    logic [WDW-1:0] wd_q;

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            wd_q <= '0;
        end else if (w_fall || (state_q == ST_IDLE)) begin
            wd_q <= '0;
        end else begin
            wd_q <= wd_q + WDW'(1);
        end
    end

    assign w_timeout = (state_q != ST_IDLE) && (wd_q == WDW'(WD_LIMIT));
`else
    logic [31:0] w_unused_cfg;
    assign w_unused_cfg = WD_LIMIT;
    assign w_timeout    = 1'b0;
`endif

    assign err_timeout = w_timeout;

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk28       (clk28),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i (shreg_q),
        .ready_i     (dout_ready),
        .dout_o      (dout),
        .valid_o     (dout_valid),
        .overflow_o  (err_overflow)
    );

endmodule

`default_nettype wire
